// File: rtl/vm2002_pkg.sv
// vm2002 shared types and constants for the stock/price table and its arbiter.
package vm2002_pkg;

    localparam int NUM_ITEMS = 8;
    localparam int ITEM_W    = $clog2(NUM_ITEMS);
    localparam int CNT_W     = 4;
    localparam int MAX_COUNT = 15;
    localparam int COST_W    = 8;
    localparam int AMT_W     = 16;

    typedef enum logic [1:0] {
        ST_OK           = 2'b00,
        ST_OUT_OF_STOCK = 2'b01,
        ST_INSUFFICIENT = 2'b10,
        ST_ERROR        = 2'b11
    } stock_status_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOOKUP = 2'b01,
        S_UPDATE = 2'b10,
        S_RESP   = 2'b11
    } arb_state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  count;
        logic [COST_W-1:0] cost;
    } stock_entry_t;

    typedef enum logic {
        REQ_VEND = 1'b0,
        REQ_SUP  = 1'b1
    } requester_t;

    // Restock sum carried one bit wider so an overflow past MAX_COUNT is visible.
    function automatic logic [CNT_W:0] restock_sum(input logic [CNT_W-1:0] count,
                                                   input logic [CNT_W-1:0] add);
        return {1'b0, count} + {1'b0, add};
    endfunction

endpackage

// File: rtl/vm2002_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win last time
// is chosen; last_winner only moves when a transaction completes (advance).
module vm2002_rr_arb2
    import vm2002_pkg::*;
(
    input  logic       clk,
    input  logic       hrst_n,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       winner
);

    logic last_winner_r;
    logic winner_s;

    // Pick the winner from the current request vector and the fairness history.
    always_comb begin
        winner_s = last_winner_r;
        case (req)
            2'b01:   winner_s = REQ_VEND;
            2'b10:   winner_s = REQ_SUP;
            2'b11:   winner_s = ~last_winner_r;
            default: winner_s = last_winner_r;
        endcase
    end

    // Remember who was served last; a soft reset leaves the history untouched.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            last_winner_r <= REQ_SUP;
        end else if (srst) begin
            last_winner_r <= last_winner_r;
        end else if (advance) begin
            last_winner_r <= winner_s;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end

    assign winner = winner_s;

endmodule

// File: rtl/vm2002_stock_arbiter.sv
// vm2002 stock/price table shared by the vend and supplier ports. Each granted
// transaction runs IDLE -> LOOKUP -> UPDATE -> RESP so every read-modify-write
// of a slot is atomic with respect to the other port.
module vm2002_stock_arbiter
    import vm2002_pkg::*;
(
    input  logic        clk,
    input  logic        hrst_n,
    input  logic        srst,
    input  logic        vend_req,
    input  logic [2:0]  vend_item,
    input  logic [15:0] vend_amount,
    output logic        vend_gnt,
    output logic        vend_done,
    output logic [1:0]  vend_status,
    output logic [15:0] vend_change,
    input  logic        sup_req,
    input  logic [2:0]  sup_item,
    input  logic [3:0]  sup_count,
    input  logic [7:0]  sup_cost,
    output logic        sup_gnt,
    output logic        sup_done,
    output logic        sup_err,
    input  logic [2:0]  peek_item,
    output logic [3:0]  peek_count,
    output logic [7:0]  peek_cost
);

    localparam logic [CNT_W:0] MAX_SUM = (CNT_W+1)'(MAX_COUNT);

    arb_state_t          state_r, state_s;
    stock_entry_t        table_r [NUM_ITEMS];
    stock_entry_t        entry_r;
    logic                owner_r;
    logic [ITEM_W-1:0]   item_r;
    logic [AMT_W-1:0]    amount_r;
    logic [CNT_W-1:0]    add_r;
    logic [COST_W-1:0]   new_cost_r;

    logic                winner_s;
    logic [1:0]          arb_req_s;
    logic                advance_s;
    logic                take_s;

    stock_status_t       status_s;
    logic [AMT_W-1:0]    change_s;
    logic                vend_wr_s;
    logic                sup_err_s;
    logic [CNT_W:0]      sum_s;

    logic                vend_gnt_r, vend_done_r, sup_gnt_r, sup_done_r, sup_err_r;
    stock_status_t       vend_status_r;
    logic [AMT_W-1:0]    vend_change_r;

    // In RESP the arbiter is shown only the finishing owner so advance records it.
    always_comb begin
        advance_s = (state_r == S_RESP);
        take_s    = (state_r == S_IDLE) && (vend_req || sup_req);
        if (state_r == S_RESP) begin
            arb_req_s = (owner_r == REQ_SUP) ? 2'b10 : 2'b01;
        end else begin
            arb_req_s = {sup_req, vend_req};
        end
    end

    vm2002_rr_arb2 u_arb (
        .clk     (clk),
        .hrst_n  (hrst_n),
        .srst    (srst),
        .req     (arb_req_s),
        .advance (advance_s),
        .winner  (winner_s)
    );

    // Next-state logic for the fixed four-step transaction.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (take_s) begin
                    state_s = S_LOOKUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOOKUP: state_s = S_UPDATE;
            S_UPDATE: state_s = S_RESP;
            S_RESP:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State register; soft reset aborts whatever is in flight.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_r <= S_IDLE;
        end else if (srst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the winner's operands at grant; they are don't-care afterwards.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            owner_r    <= REQ_SUP;
            item_r     <= 3'd0;
            amount_r   <= 16'd0;
            add_r      <= 4'd0;
            new_cost_r <= 8'd0;
        end else if (take_s && !srst) begin
            owner_r    <= winner_s;
            item_r     <= (winner_s == REQ_SUP) ? sup_item : vend_item;
            amount_r   <= vend_amount;
            add_r      <= sup_count;
            new_cost_r <= sup_cost;
        end
    end

    // Snapshot the addressed slot during LOOKUP.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            entry_r <= '{count: 4'd0, cost: 8'd0};
        end else if (state_r == S_LOOKUP) begin
            entry_r <= table_r[item_r];
        end
    end

    // Vend outcome in priority order, and restock overflow check.
    always_comb begin
        status_s  = ST_OK;
        change_s  = amount_r;
        vend_wr_s = 1'b0;
        sum_s     = restock_sum(entry_r.count, add_r);
        if (entry_r.cost == 8'd0) begin
            status_s = ST_ERROR;
        end else if (entry_r.count == 4'd0) begin
            status_s = ST_OUT_OF_STOCK;
        end else if (amount_r < {8'd0, entry_r.cost}) begin
            status_s = ST_INSUFFICIENT;
        end else begin
            status_s  = ST_OK;
            change_s  = amount_r - {8'd0, entry_r.cost};
            vend_wr_s = 1'b1;
        end
        if (sum_s > MAX_SUM) begin
            sup_err_s = 1'b1;
        end else begin
            sup_err_s = 1'b0;
        end
    end

    // Table write at the end of UPDATE; a soft reset in UPDATE suppresses it.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                table_r[i] <= '{count: 4'd0, cost: 8'd0};
            end
        end else if (!srst && (state_r == S_UPDATE)) begin
            if ((owner_r == REQ_VEND) && vend_wr_s) begin
                table_r[item_r].count <= entry_r.count - 4'd1;
            end else if ((owner_r == REQ_SUP) && !sup_err_s) begin
                table_r[item_r].count <= sum_s[CNT_W-1:0];
                if (new_cost_r != 8'd0) begin
                    table_r[item_r].cost <= new_cost_r;
                end
            end
        end
    end

    // Registered handshake pulses and results held until the next done.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            vend_gnt_r    <= 1'b0;
            sup_gnt_r     <= 1'b0;
            vend_done_r   <= 1'b0;
            sup_done_r    <= 1'b0;
            vend_status_r <= ST_OK;
            vend_change_r <= 16'd0;
            sup_err_r     <= 1'b0;
        end else if (srst) begin
            vend_gnt_r  <= 1'b0;
            sup_gnt_r   <= 1'b0;
            vend_done_r <= 1'b0;
            sup_done_r  <= 1'b0;
        end else begin
            vend_gnt_r  <= take_s && (winner_s == REQ_VEND);
            sup_gnt_r   <= take_s && (winner_s == REQ_SUP);
            vend_done_r <= (state_r == S_UPDATE) && (owner_r == REQ_VEND);
            sup_done_r  <= (state_r == S_UPDATE) && (owner_r == REQ_SUP);
            if ((state_r == S_UPDATE) && (owner_r == REQ_VEND)) begin
                vend_status_r <= status_s;
                vend_change_r <= change_s;
            end
            if ((state_r == S_UPDATE) && (owner_r == REQ_SUP)) begin
                sup_err_r <= sup_err_s;
            end
        end
    end

    assign vend_gnt    = vend_gnt_r;
    assign vend_done   = vend_done_r;
    assign vend_status = vend_status_r;
    assign vend_change = vend_change_r;
    assign sup_gnt     = sup_gnt_r;
    assign sup_done    = sup_done_r;
    assign sup_err     = sup_err_r;
    assign peek_count  = table_r[peek_item].count;
    assign peek_cost   = table_r[peek_item].cost;

endmodule

// File: tb/tb_vm2002_stock_arbiter.sv
// Bench for vm2002_stock_arbiter: a transaction-level model predicts pulses,
// results and table contents every cycle; directed scenarios add literal checks.
module tb_vm2002_stock_arbiter;

    logic        clk = 1'b0;
    logic        hrst_n, srst;
    logic        vend_req, sup_req;
    logic [2:0]  vend_item, sup_item, peek_item;
    logic [15:0] vend_amount;
    logic [3:0]  sup_count;
    logic [7:0]  sup_cost;
    logic        vend_gnt, vend_done, sup_gnt, sup_done, sup_err;
    logic [1:0]  vend_status;
    logic [15:0] vend_change;
    logic [3:0]  peek_count;
    logic [7:0]  peek_cost;

    int errors = 0;
    int checks = 0;

    vm2002_stock_arbiter dut (
        .clk(clk), .hrst_n(hrst_n), .srst(srst),
        .vend_req(vend_req), .vend_item(vend_item), .vend_amount(vend_amount),
        .vend_gnt(vend_gnt), .vend_done(vend_done), .vend_status(vend_status),
        .vend_change(vend_change),
        .sup_req(sup_req), .sup_item(sup_item), .sup_count(sup_count),
        .sup_cost(sup_cost), .sup_gnt(sup_gnt), .sup_done(sup_done), .sup_err(sup_err),
        .peek_item(peek_item), .peek_count(peek_count), .peek_cost(peek_cost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int m_count [8];
    int m_cost  [8];
    int m_last;                 // 0 = vend served last, 1 = supplier
    int cyc, acc, free_at;
    bit pend;
    int t_owner, t_item, t_status, t_change, t_err, t_newcount, t_newcost;
    bit t_write;
    int c, p;
    bit e_vgnt, e_sgnt, e_vdone, e_sdone;
    int e_status, e_change, e_err;

    always @(posedge clk or negedge hrst_n) begin : model
        if (!hrst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_count[i] = 0;
                m_cost[i]  = 0;
            end
            m_last = 1; cyc = 0; acc = 0; free_at = 0; pend = 0;
            e_vgnt = 0; e_sgnt = 0; e_vdone = 0; e_sdone = 0;
            e_status = 0; e_change = 0; e_err = 0;
        end else begin
            cyc++;
            e_vgnt = 0; e_sgnt = 0; e_vdone = 0; e_sdone = 0;
            if (srst) begin
                pend    = 0;
                free_at = cyc + 1;
            end else begin
                if (pend && cyc == acc + 2) begin
                    if (t_owner == 0) begin
                        e_vdone = 1; e_status = t_status; e_change = t_change;
                    end else begin
                        e_sdone = 1; e_err = t_err;
                    end
                    if (t_write) begin
                        m_count[t_item] = t_newcount;
                        m_cost[t_item]  = t_newcost;
                    end
                end
                if (pend && cyc == acc + 3) begin
                    m_last = t_owner;
                    pend   = 0;
                end
                if (!pend && cyc >= free_at && (vend_req || sup_req)) begin
                    t_owner = (vend_req && sup_req) ? 1 - m_last : (sup_req ? 1 : 0);
                    acc = cyc; pend = 1; free_at = cyc + 4; t_write = 0;
                    if (t_owner == 0) begin
                        e_vgnt = 1;
                        t_item = vend_item; c = m_count[t_item]; p = m_cost[t_item];
                        t_change = vend_amount; t_newcost = p;
                        if (p == 0)                t_status = 3;
                        else if (c == 0)           t_status = 1;
                        else if (vend_amount < p)  t_status = 2;
                        else begin
                            t_status = 0; t_change = vend_amount - p;
                            t_write = 1; t_newcount = c - 1;
                        end
                    end else begin
                        e_sgnt = 1;
                        t_item = sup_item; c = m_count[t_item]; p = m_cost[t_item];
                        t_err = (c + sup_count > 15) ? 1 : 0;
                        if (t_err == 0) begin
                            t_write = 1; t_newcount = c + sup_count;
                            t_newcost = (sup_cost != 0) ? sup_cost : p;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model while out of hard reset.
    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            if (hrst_n) begin
                chk("vend_gnt", vend_gnt, e_vgnt);
                chk("sup_gnt", sup_gnt, e_sgnt);
                chk("vend_done", vend_done, e_vdone);
                chk("sup_done", sup_done, e_sdone);
                chk("vend_status", vend_status, e_status);
                chk("vend_change", vend_change, e_change);
                chk("sup_err", sup_err, e_err);
                chk("peek_count", peek_count, m_count[peek_item]);
                chk("peek_cost", peek_cost, m_cost[peek_item]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_pulse(input string name, input int which, output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            case (which)
                0: seen = vend_gnt;
                1: seen = vend_done;
                2: seen = sup_gnt;
                default: seen = sup_done;
            endcase
        end
        if (!seen) chk(name, 32'd0, 32'd1);
    endtask

    task automatic vend(input logic [2:0] it, input logic [15:0] amt,
                        output logic [1:0] st, output logic [15:0] chg);
        bit seen;
        @(negedge clk); vend_req = 1'b1; vend_item = it; vend_amount = amt;
        wait_pulse("vend_gnt_timeout", 0, seen);
        @(negedge clk); vend_req = 1'b0;
        wait_pulse("vend_done_timeout", 1, seen);
        st = vend_status; chg = vend_change;
    endtask

    task automatic restock(input logic [2:0] it, input logic [3:0] n, input logic [7:0] cost,
                           output logic err);
        bit seen;
        @(negedge clk); sup_req = 1'b1; sup_item = it; sup_count = n; sup_cost = cost;
        wait_pulse("sup_gnt_timeout", 2, seen);
        @(negedge clk); sup_req = 1'b0;
        wait_pulse("sup_done_timeout", 3, seen);
        err = sup_err;
    endtask

    task automatic tie(input logic [2:0] vi, input logic [15:0] va,
                       input logic [2:0] si, input logic [3:0] sn, input logic [7:0] sc,
                       output int vg, output int sg, output logic [1:0] vst,
                       output logic [15:0] vchg, output logic serr);
        @(negedge clk);
        vend_req = 1'b1; vend_item = vi; vend_amount = va;
        sup_req = 1'b1; sup_item = si; sup_count = sn; sup_cost = sc;
        vg = -1; sg = -1; vst = 2'b00; vchg = 16'd0; serr = 1'b0;
        for (int cy = 0; cy < 16; cy++) begin
            @(posedge clk); #1;
            if (vend_gnt) vg = cy;
            if (sup_gnt) sg = cy;
            if (vend_done) begin vst = vend_status; vchg = vend_change; end
            if (sup_done) serr = sup_err;
            @(negedge clk);
            if (vg >= 0) vend_req = 1'b0;
            if (sg >= 0) sup_req = 1'b0;
        end
    endtask

    task automatic peek_chk(input string name, input logic [2:0] it,
                            input logic [3:0] cnt, input logic [7:0] cost);
        @(negedge clk); peek_item = it; #1;
        chk({name, "_count"}, peek_count, cnt);
        chk({name, "_cost"}, peek_cost, cost);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [1:0]  st;
        logic [15:0] chg;
        logic        err;
        int          vg, sg;
        bit          seen_done;

        hrst_n = 1'b0; srst = 1'b0; vend_req = 1'b0; sup_req = 1'b0;
        vend_item = 3'd0; vend_amount = 16'd0; sup_item = 3'd0;
        sup_count = 4'd0; sup_cost = 8'd0; peek_item = 3'd2;
        #12;
        chk("rst_vend_gnt", vend_gnt, 1'b0);
        chk("rst_status", vend_status, 2'b00);
        chk("rst_change", vend_change, 16'd0);
        chk("rst_sup_err", sup_err, 1'b0);
        chk("rst_peek", peek_count, 4'd0);
        @(negedge clk); hrst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First tie after reset: vend wins, supplier 4 cycles later.
        tie(3'd5, 16'd77, 3'd2, 4'd5, 8'h4B, vg, sg, st, chg, err);
        chk("tie1_vend_first", vg, 32'd0);
        chk("tie1_sup_gnt", sg, 32'd4);
        chk("tie1_vend_status", st, 2'b11);
        chk("tie1_vend_change", chg, 16'd77);
        chk("tie1_sup_err", err, 1'b0);
        peek_chk("restock2", 3'd2, 4'd5, 8'h4B);

        // Vend OK: 100 - 75 = 25.
        vend(3'd2, 16'd100, st, chg);
        chk("vend_ok_status", st, 2'b00);
        chk("vend_ok_change", chg, 16'd25);
        peek_chk("after_vend", 3'd2, 4'd4, 8'h4B);

        // Vend served last, so this tie goes to the supplier.
        tie(3'd2, 16'd50, 3'd6, 4'd1, 8'd9, vg, sg, st, chg, err);
        chk("tie2_sup_first", sg, 32'd0);
        chk("tie2_vend_gnt", vg, 32'd4);
        chk("insuff_status", st, 2'b10);
        chk("insuff_change", chg, 16'd50);
        peek_chk("after_insuff", 3'd2, 4'd4, 8'h4B);

        vend(3'd5, 16'd40, st, chg);
        chk("err_status", st, 2'b11);
        chk("err_change", chg, 16'd40);

        // Price-only update, then out of stock.
        restock(3'd3, 4'd0, 8'd20, err);
        chk("price_only_err", err, 1'b0);
        peek_chk("price_only", 3'd3, 4'd0, 8'd20);
        vend(3'd3, 16'd30, st, chg);
        chk("oos_status", st, 2'b01);
        chk("oos_change", chg, 16'd30);

        // Restock to 12, then overflow leaves the slot untouched.
        restock(3'd2, 4'd8, 8'd0, err);
        chk("restock12_err", err, 1'b0);
        restock(3'd2, 4'd4, 8'h10, err);
        chk("overflow_err", err, 1'b1);
        peek_chk("overflow", 3'd2, 4'd12, 8'h4B);

        // Boundaries: sum exactly 15, and amount exactly equal to cost.
        restock(3'd6, 4'd14, 8'd0, err);
        chk("sum15_err", err, 1'b0);
        vend(3'd6, 16'd9, st, chg);
        chk("exact_status", st, 2'b00);
        chk("exact_change", chg, 16'd0);
        peek_chk("exact", 3'd6, 4'd14, 8'd9);

        // Soft reset in UPDATE: no done, no write.
        peek_item = 3'd2;
        @(negedge clk); vend_req = 1'b1; vend_item = 3'd2; vend_amount = 16'd100;
        wait_pulse("srst_gnt_timeout", 0, seen_done);
        @(negedge clk); vend_req = 1'b0;
        @(negedge clk); srst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vend_done) seen_done = 1;
            @(negedge clk); srst = 1'b0;
        end
        chk("srst_no_done", seen_done, 1'b0);
        peek_chk("srst_table", 3'd2, 4'd12, 8'h4B);
        vend(3'd2, 16'd100, st, chg);
        chk("post_srst_status", st, 2'b00);
        chk("post_srst_change", chg, 16'd25);

        // Hard reset mid-transaction clears everything without a clock edge.
        @(negedge clk); vend_req = 1'b1; vend_item = 3'd2; vend_amount = 16'd100; peek_item = 3'd2;
        wait_pulse("hrst_gnt_timeout", 0, seen_done);
        @(negedge clk); vend_req = 1'b0;
        @(posedge clk); #3;
        hrst_n = 1'b0;
        #1;
        chk("hrst_done", vend_done, 1'b0);
        chk("hrst_status", vend_status, 2'b00);
        chk("hrst_change", vend_change, 16'd0);
        chk("hrst_sup_err", sup_err, 1'b0);
        chk("hrst_peek_count", peek_count, 4'd0);
        chk("hrst_peek_cost", peek_cost, 8'd0);
        @(negedge clk); hrst_n = 1'b1;
        repeat (2) @(negedge clk);
        vend(3'd2, 16'd100, st, chg);
        chk("post_hrst_status", st, 2'b11);
        chk("post_hrst_change", chg, 16'd100);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vm2002_stock_arbiter.md
Name: vm2002_stock_arbiter

Overview:
- Owns the vm2002 item stock/price table: 8 slots, each a 4-bit count and an 8-bit cost.
- Two requesters share it through a round-robin arbiter, one transaction at a time:
  - vend port, driven by the vending FSM: check stock, check payment, decrement, compute change;
  - supplier port: restock count and update price.
- Each granted transaction is a fixed read-modify-write sequence, so stock and price updates are never lost or torn.

Parameters:
- NUM_ITEMS, 8, number of table slots (item index width is clog2(NUM_ITEMS) = 3).
- CNT_W, 4, per-item count width.
- MAX_COUNT, 15, maximum legal stock per item.
- COST_W, 8, price width in cents.
- AMT_W, 16, inserted-amount and change width in cents.

Ports:
- clk  in  1  single clock, all state on rising edge
- hrst_n  in  1  reset, asynchronous assert, active-low
- srst  in  1  synchronous soft reset, active-high
- vend_req  in  1  vend request, level; held until vend_gnt
- vend_item  in  3  requested item index
- vend_amount  in  16  amount inserted, cents
- vend_gnt  out  1  one-cycle pulse; operands captured
- vend_done  out  1  one-cycle pulse; result valid
- vend_status  out  2  00 OK, 01 OUT_OF_STOCK, 10 INSUFFICIENT, 11 ERROR
- vend_change  out  16  amount minus cost on OK, else vend_amount (full refund)
- sup_req  in  1  restock request, level; held until sup_gnt
- sup_item  in  3  item index
- sup_count  in  4  units added
- sup_cost  in  8  new price; 0 keeps the existing price
- sup_gnt  out  1  one-cycle pulse
- sup_done  out  1  one-cycle pulse
- sup_err  out  1  valid with sup_done; 1 = overflow, nothing written
- peek_item  in  3  display read index
- peek_count  out  4  combinational table read
- peek_cost  out  8  combinational table read

Behaviour:
- Reset:
  - hrst_n low, asynchronously: every count and cost = 0, state = IDLE, last_winner = SUP.
  - All pulse outputs = 0; vend_status = 00, vend_change = 0, sup_err = 0.
- srst, synchronous:
  - State returns to IDLE; all pulses cleared; any in-flight transaction is aborted with no table write and no done.
  - The table is retained. last_winner is unchanged.
- States: IDLE -> LOOKUP -> UPDATE -> RESP -> IDLE. Fixed 4 cycles per transaction.
  - IDLE: if any req is high, pick a winner, capture its operands, and go to LOOKUP. The winner's gnt is high for exactly the LOOKUP cycle. If no req, stay.
  - LOOKUP: register the table entry (count, cost) for the captured item.
  - UPDATE: compute the result and write the table if required.
  - RESP: the winner's done = 1 for this cycle only; results are valid and held until the next done; last_winner updated.
- Latency: req sampled high at edge N -> gnt in cycle N+1 -> done in cycle N+3. Back-to-back throughput is one transaction per 4 cycles.
- Arbitration:
  - One requester: it wins.
  - Both high: the requester that is not last_winner wins. After reset the vend port wins the first tie.
  - The loser keeps req high and is served next.
- Requester rules:
  - Drop req or present a new request in the cycle after gnt. A req still high in IDLE is treated as a new request.
  - Operands are don't-care after gnt.
- Vend result, evaluated in this priority order:
  1. cost == 0 -> ERROR (unpriced item).
  2. count == 0 -> OUT_OF_STOCK.
  3. vend_amount < cost (cost zero-extended to 16 bits) -> INSUFFICIENT.
  4. Otherwise OK: count decrements by 1, change = amount - cost.
  - Only OK writes the table. Non-OK outcomes set change = vend_amount.
- Restock result:
  - Sum is computed 5 bits wide (count + sup_count).
  - Sum > MAX_COUNT -> sup_err = 1; neither count nor cost is written.
  - Otherwise count = sum, and cost = sup_cost if sup_cost != 0.
  - sup_count = 0 is legal and allows a price-only update.
- Peek: combinational read of the current table. A write in UPDATE is visible from the next cycle.
- Same item requested on both ports: the requests are serialized. The second transaction sees the first one's write.

Decomposition:
- vm2002_pkg gains:
  - stock_status_t enum (OK, OUT_OF_STOCK, INSUFFICIENT, ERROR);
  - arb_state_t enum (IDLE, LOOKUP, UPDATE, RESP);
  - stock_entry_t packed struct {count[3:0], cost[7:0]};
  - requester_t enum (VEND, SUP);
  - MAX_COUNT constant.
- One sub-module: vm2002_rr_arb2. It is the 2-way round-robin picker holding last_winner, with inputs req[1:0], advance, srst and output winner.

Test Plan:
- Restock: after reset, sup item 2, count 5, cost 0x4B -> sup_gnt at +1, sup_done at +3, sup_err 0; peek item 2 reads count 5, cost 0x4B.
- Vend OK: vend item 2, amount 100 -> status OK, change 25; count becomes 4.
- Vend refusals, all with no table change:
  - amount 50 -> INSUFFICIENT, change 50;
  - item 5 (count 0, cost 0) -> ERROR;
  - item 3 (cost 20, count 0) -> OUT_OF_STOCK.
- Overflow: item 2 at count 12, sup_count 4, sup_cost 0x10 -> sup_err 1; count stays 12, cost unchanged.
- Arbitration tie: vend_req and sup_req both rise in the same cycle after reset -> vend granted first, sup granted 4 cycles later. Next tie -> sup wins.
- Resets:
  - srst asserted in the UPDATE cycle -> no done, table unchanged, IDLE next cycle.
  - hrst_n pulsed low mid-transaction -> all outputs and the table clear immediately, without waiting for a clock edge.
